// File: rtl/clause_merge_tree.sv
// Batch-fed binary merge tree: clause batches are spread over leaf FIFOs, then merged
// pairwise by round-robin nodes into a single first-word-fall-through root FIFO.
module clause_merge_tree #(
  parameter int CLAUSE_COUNT = 20,
  parameter int CLAUSE_WIDTH = 36,
  parameter int LEAF_COUNT   = 4,
  parameter int BUFFER_DEPTH = 32,
  localparam int CNT_W = $clog2(((2*LEAF_COUNT-1)*BUFFER_DEPTH)+CLAUSE_COUNT+1)
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [CLAUSE_WIDTH*CLAUSE_COUNT-1:0] clauses_i,
  input  logic [CLAUSE_COUNT-1:0]              clause_valid_i,
  input  logic                                 wren_i,
  output logic                                 ready_o,
  input  logic                                 rden_i,
  output logic                                 empty_o,
  output logic [CLAUSE_WIDTH-1:0]              clause_o,
  output logic                                 busy_o,
  output logic [CNT_W-1:0]                     count_o,
  output logic                                 OF_o,
  input  logic                                 cOF_i
);

  localparam int LANES = CLAUSE_COUNT / LEAF_COUNT;
  localparam int NN    = LEAF_COUNT - 1;      // merge nodes, heap-indexed 0..NN-1 (0 = root)
  localparam int NF    = 2*LEAF_COUNT - 1;    // all FIFOs; leaf k lives at index NN+k
  localparam int PW    = $clog2(BUFFER_DEPTH);
  localparam int OW    = PW + 1;
  localparam int JW    = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [OW-1:0] DEPTH_O = OW'(BUFFER_DEPTH);
  localparam logic [OW-1:0] LANES_O = OW'(LANES);

  logic [CLAUSE_WIDTH-1:0] mem_q [NF][BUFFER_DEPTH];
  logic [PW-1:0]           wp_q  [NF];
  logic [PW-1:0]           rp_q  [NF];
  logic [OW-1:0]           occ_q [NF];

  logic [NN-1:0]           infl_v_q;
  logic [CLAUSE_WIDTH-1:0] infl_d_q [NN];
  logic [NN-1:0]           rr_q;

  logic [CLAUSE_WIDTH*CLAUSE_COUNT-1:0] batch_q;
  logic [CLAUSE_COUNT-1:0]              bvalid_q;
  logic                                 busy_q;
  logic [JW-1:0]                        lane_q;
  logic                                 init_q;
  logic [CNT_W-1:0]                     count_q, count_d;
  logic                                 of_q;
  logic [CLAUSE_WIDTH-1:0]              last_q;

  logic [NF-1:0]           pop, wr;
  logic [CLAUSE_WIDTH-1:0] wdata [NF];
  logic [CLAUSE_WIDTH-1:0] head  [NF];
  logic [NN-1:0]           grant_v, grant_c;
  logic                    leaves_room, accept, drop;
  logic [CNT_W-1:0]        batch_cnt;

  always_comb begin
    for (int f = 0; f < NF; f++) head[f] = mem_q[f][rp_q[f]];
  end

  // Pop/push decisions for every FIFO in the tree.
  always_comb begin
    // NOTE: every variable gets a default first so this block can never infer a latch.
    pop     = '0;
    wr      = '0;
    grant_v = '0;
    grant_c = '0;
    for (int f = 0; f < NF; f++) wdata[f] = '0;

    pop[0] = rden_i && (occ_q[0] != '0);

    for (int n = 0; n < NN; n++) begin
      // The in-flight entry counts as occupied so a node can never overflow.
      grant_v[n] = ((occ_q[n] + OW'(infl_v_q[n])) < DEPTH_O) &&
                   ((occ_q[2*n+1] != '0) || (occ_q[2*n+2] != '0));
      grant_c[n] = ((occ_q[2*n+1] != '0) && (occ_q[2*n+2] != '0)) ? rr_q[n]
                                                                    : (occ_q[2*n+2] != '0);
      if (grant_v[n]) pop[2*n+1+int'(grant_c[n])] = 1'b1;
      wr[n]    = infl_v_q[n];
      wdata[n] = infl_d_q[n];
    end

    for (int k = 0; k < LEAF_COUNT; k++) begin
      wr[NN+k]    = busy_q && bvalid_q[k*LANES+int'(lane_q)];
      wdata[NN+k] = batch_q[(k*LANES+int'(lane_q))*CLAUSE_WIDTH +: CLAUSE_WIDTH];
    end
  end

  always_comb begin
    leaves_room = 1'b1;
    for (int k = 0; k < LEAF_COUNT; k++) begin
      if ((DEPTH_O - occ_q[NN+k] + OW'(pop[NN+k])) < LANES_O) leaves_room = 1'b0;
    end
    ready_o = init_q && !busy_q && leaves_room;
    accept  = wren_i && ready_o;
    drop    = wren_i && !ready_o;

    batch_cnt = '0;
    for (int i = 0; i < CLAUSE_COUNT; i++) batch_cnt = batch_cnt + CNT_W'(clause_valid_i[i]);
    count_d = count_q + (accept ? batch_cnt : '0) - CNT_W'(pop[0]);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int f = 0; f < NF; f++) begin
        wp_q[f]  <= '0;
        rp_q[f]  <= '0;
        occ_q[f] <= '0;
      end
      for (int n = 0; n < NN; n++) infl_d_q[n] <= '0;
      infl_v_q <= '0;
      rr_q     <= '0;
      batch_q  <= '0;
      bvalid_q <= '0;
      busy_q   <= 1'b0;
      lane_q   <= '0;
      init_q   <= 1'b0;
      count_q  <= '0;
      of_q     <= 1'b0;
      last_q   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      init_q <= 1'b1;
      for (int f = 0; f < NF; f++) begin
        if (wr[f])  wp_q[f] <= wp_q[f] + PW'(1);
        if (pop[f]) rp_q[f] <= rp_q[f] + PW'(1);
        occ_q[f] <= occ_q[f] + OW'(wr[f]) - OW'(pop[f]);
      end

      infl_v_q <= grant_v;
      for (int n = 0; n < NN; n++) begin
        if (grant_v[n]) begin
          infl_d_q[n] <= head[2*n+1+int'(grant_c[n])];
          rr_q[n]     <= ~grant_c[n];
        end
      end

      if (accept) begin
        batch_q  <= clauses_i;
        bvalid_q <= clause_valid_i;
        busy_q   <= 1'b1;
        lane_q   <= '0;
      end else if (busy_q) begin
        lane_q <= lane_q + JW'(1);
        if (lane_q == JW'(LANES-1)) busy_q <= 1'b0;
      end

      count_q <= count_d;

      if (cOF_i)     of_q <= 1'b0;
      else if (drop) of_q <= 1'b1;

      if (occ_q[0] != '0) last_q <= head[0];
    end
  end

  // NOTE: storage arrays are not reset; occupancy and pointers alone define what is valid.
  always_ff @(posedge clk) begin
    for (int f = 0; f < NF; f++) begin
      if (wr[f]) mem_q[f][wp_q[f]] <= wdata[f];
    end
  end

  assign empty_o  = (occ_q[0] == '0);
  assign clause_o = empty_o ? last_q : head[0];
  assign busy_o   = busy_q;
  assign count_o  = count_q;
  assign OF_o     = of_q;

endmodule
